// File: rtl/id_serializer.sv
// Serial identifier transmitter: ID_STR MSB-first on id_data/id_valid, 0x00 terminator, then a gap.
// Optional build macro ID_SERIALIZER_ONESHOT_EN: send exactly one frame per reset, then park in DONE.
module id_serializer #(
  parameter int unsigned         ID_LEN     = 8,
  parameter logic [8*ID_LEN-1:0] ID_STR     = "beepboop",
  parameter int unsigned         GAP_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic id_valid,
  output logic id_data,
  output logic busy,
  output logic done_pulse
);

  localparam int unsigned CW = $clog2(ID_LEN + 1);
  localparam int unsigned GW = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
`ifdef ID_SERIALIZER_ONESHOT_EN
  localparam logic [1:0] DONE = 2'd3;
`endif

  logic [1:0]    state, state_n;
  logic [CW-1:0] char_idx, char_n;
  logic [2:0]    bit_idx, bit_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic          cur_zero;
  logic [7:0]    nxt_char;
  logic          id_valid_n, id_data_n, busy_n, done_n;

  // Character lookup; index ID_LEN (the terminator slot) yields 0x00.
  function automatic logic [7:0] char_at(input logic [CW-1:0] idx);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < int'(ID_LEN); i++) begin
      if (idx == CW'(i)) c = ID_STR[8*(int'(ID_LEN)-1-i) +: 8];
    end
    return c;
  endfunction

  // Next-state and next-output logic; outputs describe the cycle after the edge.
  always_comb begin
    state_n  = state;
    char_n   = char_idx;
    bit_n    = bit_idx;
    gap_n    = gap_cnt;
    cur_zero = (char_idx != CW'(ID_LEN)) && (char_at(char_idx) == 8'h00);

    case (state)
      IDLE: begin
        if (enable) begin
          state_n = SEND;
          char_n  = '0;
          bit_n   = 3'd7;
        end
      end
      SEND: begin
        if (cur_zero) begin
          // Padding characters occupy one silent cycle and emit no bits.
          char_n = char_idx + CW'(1);
          bit_n  = 3'd7;
        end else if (bit_idx == 3'd0) begin
          bit_n = 3'd7;
          if (char_idx == CW'(ID_LEN)) begin
            state_n = GAP;
            gap_n   = '0;
            char_n  = '0;
          end else begin
            char_n = char_idx + CW'(1);
          end
        end else begin
          bit_n = bit_idx - 3'd1;
        end
      end
      GAP: begin
        if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
`ifdef ID_SERIALIZER_ONESHOT_EN
          state_n = DONE;
`else
          state_n = enable ? SEND : IDLE;
`endif
          gap_n  = '0;
          char_n = '0;
          bit_n  = 3'd7;
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
`ifdef ID_SERIALIZER_ONESHOT_EN
      DONE: state_n = DONE;
`endif
      default: state_n = IDLE;
    endcase

    nxt_char   = char_at(char_n);
    busy_n     = (state_n == SEND);
    id_valid_n = busy_n && ((char_n == CW'(ID_LEN)) || (nxt_char != 8'h00));
    id_data_n  = busy_n && nxt_char[bit_n];
    done_n     = (state == SEND) && (state_n != SEND);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      char_idx   <= '0;
      bit_idx    <= 3'd7;
      gap_cnt    <= '0;
      id_valid   <= 1'b0;
      id_data    <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_n;
      char_idx   <= char_n;
      bit_idx    <= bit_n;
      gap_cnt    <= gap_n;
      id_valid   <= id_valid_n;
      id_data    <= id_data_n;
      busy       <= busy_n;
      done_pulse <= done_n;
    end
  end

endmodule

// File: tb/tb_id_serializer.sv
// Scoreboard bench for id_serializer: default string instance plus a padded-string instance.
module tb_id_serializer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic enable_b = 1'b0;
  logic id_valid, id_data, busy, done_pulse;
  logic b_valid, b_data, b_busy, b_done;

  logic [3:0] qa[$];
  logic [3:0] qb[$];
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [71:0] RX_A = {"beepboop", 8'h00};
  localparam logic [31:0] RX_B = {"abc", 8'h00};

  always #5 clock = ~clock;

  id_serializer dut_a (
    .clock(clock), .reset(reset), .enable(enable),
    .id_valid(id_valid), .id_data(id_data), .busy(busy), .done_pulse(done_pulse)
  );

  id_serializer #(.ID_LEN(4), .ID_STR({8'h00, "abc"}), .GAP_CYCLES(16)) dut_b (
    .clock(clock), .reset(reset), .enable(enable_b),
    .id_valid(b_valid), .id_data(b_data), .busy(b_busy), .done_pulse(b_done)
  );

  // Expected entries are {id_valid, id_data, busy, done_pulse}.
  task automatic push_one(input bit sel, input logic [3:0] v);
    if (sel) qb.push_back(v);
    else qa.push_back(v);
  endtask

  task automatic push_frame(input bit sel, input logic [255:0] s, input int len);
    logic [7:0] ch;
    for (int c = 0; c < len; c++) begin
      ch = s[8*(len-1-c) +: 8];
      if (ch == 8'h00) push_one(sel, 4'b0010);
      else for (int b = 7; b >= 0; b--) push_one(sel, {1'b1, ch[b], 2'b10});
    end
    for (int b = 0; b < 8; b++) push_one(sel, 4'b1010);
  endtask

  task automatic push_gap(input bit sel);
    push_one(sel, 4'b0001);
    for (int k = 1; k < 16; k++) push_one(sel, 4'b0000);
  endtask

  task automatic push_idle(input bit sel, input int n);
    for (int k = 0; k < n; k++) push_one(sel, 4'b0000);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    enable_b = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] obsv;
    reset = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      obsv = {id_valid, id_data, busy, done_pulse, b_valid, b_data, b_busy, b_done};
      n_cmp++;
      if (obsv !== 8'h00) begin
        n_err++;
        $display("FAIL reset cyc %0d: got %b want 00000000", i, obsv);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] expv, obsv;
    logic [71:0] rx;
    int tot;
    rx = '0;
    push_frame(1'b0, {192'd0, "beepboop"}, 8);
    push_gap(1'b0);
`ifdef ID_SERIALIZER_ONESHOT_EN
    push_idle(1'b0, 500);
`else
    push_frame(1'b0, {192'd0, "beepboop"}, 8);
    push_gap(1'b0);
    push_idle(1'b0, 10);
`endif
    tot = qa.size();
    for (int i = 0; i < tot; i++) begin
      @(posedge clock); #1;
      expv = qa.pop_front();
      obsv = {id_valid, id_data, busy, done_pulse};
      n_cmp++;
      if (obsv !== expv) begin
        n_err++;
        $display("FAIL b2b cyc %0d: got %b want %b", i + 1, obsv, expv);
      end
      if (i < 72 && id_valid) rx = {rx[70:0], id_data};
`ifndef ID_SERIALIZER_ONESHOT_EN
      if (i == 117) enable = 1'b0;
`endif
    end
    enable = 1'b0;
    n_cmp++;
    if (rx !== RX_A) begin
      n_err++;
      $display("FAIL b2b_decode: got %h want %h", rx, RX_A);
    end
  endtask

  task automatic test_single_enable();
    logic [3:0] expv, obsv;
    int tot;
    do_reset();
    enable = 1'b1;
    push_frame(1'b0, {192'd0, "beepboop"}, 8);
    push_gap(1'b0);
    push_idle(1'b0, 20);
    tot = qa.size();
    for (int i = 0; i < tot; i++) begin
      @(posedge clock); #1;
      expv = qa.pop_front();
      obsv = {id_valid, id_data, busy, done_pulse};
      n_cmp++;
      if (obsv !== expv) begin
        n_err++;
        $display("FAIL single cyc %0d: got %b want %b", i + 1, obsv, expv);
      end
      if (i == 0) enable = 1'b0;
    end
  endtask

  task automatic test_padding();
    logic [3:0] expv, obsv;
    logic [31:0] rx;
    int tot;
    rx = '0;
    do_reset();
    enable_b = 1'b1;
    push_frame(1'b1, {224'd0, 8'h00, "abc"}, 4);
    push_gap(1'b1);
    push_idle(1'b1, 5);
    tot = qb.size();
    for (int i = 0; i < tot; i++) begin
      @(posedge clock); #1;
      expv = qb.pop_front();
      obsv = {b_valid, b_data, b_busy, b_done};
      n_cmp++;
      if (obsv !== expv) begin
        n_err++;
        $display("FAIL padding cyc %0d: got %b want %b", i + 1, obsv, expv);
      end
      if (b_valid) rx = {rx[30:0], b_data};
      if (i == 0) enable_b = 1'b0;
    end
    n_cmp++;
    if (rx !== RX_B) begin
      n_err++;
      $display("FAIL padding_decode: got %h want %h", rx, RX_B);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] expv, obsv;
    int tot;
    do_reset();
    enable = 1'b1;
    push_frame(1'b0, {192'd0, "beepboop"}, 8);
    for (int i = 0; i < 20; i++) begin
      @(posedge clock); #1;
      expv = qa.pop_front();
      obsv = {id_valid, id_data, busy, done_pulse};
      n_cmp++;
      if (obsv !== expv) begin
        n_err++;
        $display("FAIL rst_mid_pre cyc %0d: got %b want %b", i + 1, obsv, expv);
      end
    end
    qa.delete();
    // Mid-cycle, away from any clock edge.
    #2 reset = 1'b1;
    #1;
    obsv = {id_valid, id_data, busy, done_pulse};
    n_cmp++;
    if (obsv !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_mid_async: got %b want 0000", obsv);
    end
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    enable = 1'b1;
    push_frame(1'b0, {192'd0, "beepboop"}, 8);
    push_gap(1'b0);
    push_idle(1'b0, 4);
    tot = qa.size();
    for (int i = 0; i < tot; i++) begin
      @(posedge clock); #1;
      expv = qa.pop_front();
      obsv = {id_valid, id_data, busy, done_pulse};
      n_cmp++;
      if (obsv !== expv) begin
        n_err++;
        $display("FAIL rst_mid_post cyc %0d: got %b want %b", i + 1, obsv, expv);
      end
      if (i == 0) enable = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_enable();
    test_padding();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
